// File: rtl/decode_lsps_scalar.sv
`default_nettype none
// ============================================================================
//  Module      : decode_lsps_scalar
//  Description : Sequential LSP decoder. For each of ten orders, reads the
//                codebook ROM entry selected by the masked index field and
//                converts the Hz value to radians (Q16.16). Coefficients are
//                emitted one at a time, in order, with lsp_valid strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_lsps_scalar #(
    parameter int             N       = 32,
    parameter int             Q       = 16,
    parameter logic [N-1:0]   HZTORAD = 32'd51
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [49:0]   indexes,
    output logic [7:0]    cb_addr,
    output logic          cb_rden,
    input  logic [N-1:0]  cb_data,
    output logic [N-1:0]  lsp_out,
    output logic [3:0]    lsp_order,
    output logic          lsp_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_EMIT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [3:0] LAST_ORDER = 4'd9;

    state_t             state_q, state_d;
    logic [3:0]         i_q;
    logic [49:0]        indexes_q;
    logic [N-1:0]       lsp_hz_q;
    logic [7:0]         cb_addr_q;
    logic               cb_rden_q;
    logic [N-1:0]       lsp_out_q;
    logic [3:0]         lsp_order_q;
    logic               lsp_valid_q;
    logic               busy_q;
    logic               done_q;

    logic [4:0]         w_fields [10];
    logic [4:0]         w_sel;
    logic [3:0]         w_mask;
    logic [3:0]         w_eff;
    logic [7:0]         w_addr;
    logic signed [2*N-1:0] w_hz_ext;
    logic signed [2*N-1:0] w_k_ext;
    logic signed [2*N-1:0] w_prod;
    logic [N-1:0]       w_rad;
    logic               w_unused;

    // Split the latched index word into its ten 5-bit fields
    always_comb begin
        for (int k = 0; k < 10; k++) begin
            w_fields[k] = indexes_q[5*k +: 5];
        end
    end

    // Codebook size mask for the current order: 16 entries, then 8, 8, 4
    always_comb begin
        w_mask = 4'hF;
        if (i_q == 4'd7 || i_q == 4'd8) begin
            w_mask = 4'h7;
        end else if (i_q == 4'd9) begin
            w_mask = 4'h3;
        end
    end

    assign w_sel  = w_fields[i_q];
    assign w_eff  = w_sel[3:0] & w_mask;
    assign w_addr = {i_q, 4'b0000} + {4'b0000, w_eff};

    // Hz -> rad: signed full-width product, keep the middle word (truncating)
    assign w_hz_ext = {{N{lsp_hz_q[N-1]}}, lsp_hz_q};
    assign w_k_ext  = {{N{HZTORAD[N-1]}}, HZTORAD};
    assign w_prod   = w_hz_ext * w_k_ext;
    assign w_rad    = w_prod[Q+N-1:Q];
    assign w_unused = ^{w_prod[2*N-1:Q+N], w_prod[Q-1:0], w_sel[4]};

    // Next-state logic; one pass ISSUE->WAIT->CAPTURE->EMIT per order
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_EMIT;
            S_EMIT:    state_d = (i_q == LAST_ORDER) ? S_DONE : S_ISSUE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State register plus datapath and registered outputs keyed on current state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            i_q         <= 4'd0;
            indexes_q   <= '0;
            lsp_hz_q    <= '0;
            cb_addr_q   <= 8'd0;
            cb_rden_q   <= 1'b0;
            lsp_out_q   <= '0;
            lsp_order_q <= 4'd0;
            lsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cb_rden_q   <= 1'b0;
            lsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        indexes_q <= indexes;
                        i_q       <= 4'd0;
                    end
                end
                S_ISSUE: begin
                    cb_addr_q <= w_addr;
                    cb_rden_q <= 1'b1;
                end
                S_CAPTURE: begin
                    lsp_hz_q <= cb_data;
                end
                S_EMIT: begin
                    lsp_out_q   <= w_rad;
                    lsp_order_q <= i_q;
                    lsp_valid_q <= 1'b1;
                    if (i_q != LAST_ORDER) begin
                        i_q <= i_q + 4'd1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign cb_addr   = cb_addr_q;
    assign cb_rden   = cb_rden_q;
    assign lsp_out   = lsp_out_q;
    assign lsp_order = lsp_order_q;
    assign lsp_valid = lsp_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_lsps_scalar.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_lsps_scalar
//  Description : Scoreboard bench for decode_lsps_scalar with a codebook ROM
//                model and a rule-level reference decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_lsps_scalar;

    logic        clk;
    logic        rst;
    logic        start;
    logic [49:0] indexes;
    logic [7:0]  cb_addr;
    logic        cb_rden;
    logic [31:0] cb_data;
    logic [31:0] lsp_out;
    logic [3:0]  lsp_order;
    logic        lsp_valid;
    logic        busy;
    logic        done;

    logic [31:0] rom [256];
    int          cyc;
    int          total;
    int          bad;

    typedef struct { int ord; logic [31:0] val; int t; } lsp_exp_t;
    typedef struct { int addr; int t; } addr_exp_t;

    lsp_exp_t  q_lsp  [$];
    addr_exp_t q_addr [$];
    int        q_done [$];

    decode_lsps_scalar dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .indexes   (indexes),
        .cb_addr   (cb_addr),
        .cb_rden   (cb_rden),
        .cb_data   (cb_data),
        .lsp_out   (lsp_out),
        .lsp_order (lsp_order),
        .lsp_valid (lsp_valid),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after posedge k, cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    // Codebook ROM: address sampled with read enable, data held until next read
    always @(posedge clk) if (cb_rden) cb_data <= rom[cb_addr];

    function automatic void chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [49:0] rand50();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[49:0];
    endfunction

    // Hz (Q16.16) times pi/4000 (51 in Q16.16), arithmetic shift back by 16
    function automatic logic [31:0] ref_rad(input logic [31:0] hz);
        longint p;
        p = longint'($signed(hz)) * 64'sd51;
        p = p >>> 16;
        return p[31:0];
    endfunction

    // Expected ROM reads, coefficients and done for a frame started at edge e0
    function automatic void push_frame(input logic [49:0] idx, input int e0);
        for (int i = 0; i < 10; i++) begin
            int        m;
            int        f;
            int        a;
            lsp_exp_t  le;
            addr_exp_t ae;
            m = (i < 7) ? 16 : ((i < 9) ? 8 : 4);
            f = int'(idx[5*i +: 5]);
            a = 16 * i + (f % m);
            ae.addr = a;
            ae.t    = e0 + 4 * i + 1;
            q_addr.push_back(ae);
            le.ord = i;
            le.val = ref_rad(rom[a]);
            le.t   = e0 + 4 * (i + 1);
            q_lsp.push_back(le);
        end
        q_done.push_back(e0 + 41);
    endfunction

    // Monitor: every strobe must match the head of its expectation queue
    lsp_exp_t  m_le;
    addr_exp_t m_ae;
    int        m_dt;
    always @(negedge clk) begin
        if (rst) begin
            if (lsp_valid) begin
                if (q_lsp.size() == 0) chk("spurious_lsp_valid", 1, 0);
                else begin
                    m_le = q_lsp.pop_front();
                    chk("lsp_out", lsp_out, m_le.val);
                    chk("lsp_order", lsp_order, m_le.ord);
                    chk("lsp_valid_cycle", cyc, m_le.t);
                end
            end
            if (cb_rden) begin
                if (q_addr.size() == 0) chk("spurious_cb_rden", 1, 0);
                else begin
                    m_ae = q_addr.pop_front();
                    chk("cb_addr", cb_addr, m_ae.addr);
                    chk("cb_rden_cycle", cyc, m_ae.t);
                end
            end
            if (done) begin
                if (q_done.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    m_dt = q_done.pop_front();
                    chk("done_cycle", cyc, m_dt);
                end
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_cb_addr"}, cb_addr, 0);
        chk({tag, "_cb_rden"}, cb_rden, 0);
        chk({tag, "_lsp_out"}, lsp_out, 0);
        chk({tag, "_lsp_order"}, lsp_order, 0);
        chk({tag, "_lsp_valid"}, lsp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Called at a negedge: start one frame, optionally poke start at edge e0+10
    task automatic run_frame(input logic [49:0] idx, input bit poke);
        int e0;
        indexes = idx;
        start   = 1'b1;
        e0      = cyc + 1;
        push_frame(idx, e0);
        @(negedge clk);
        start   = 1'b0;
        indexes = rand50();
        chk("busy_after_e0", busy, 0);
        while (cyc < e0 + 42 && cyc < e0 + 100) begin
            @(negedge clk);
            if (cyc == e0 + 1)  chk("busy_first", busy, 1);
            if (cyc == e0 + 41) chk("busy_last", busy, 1);
            if (poke && cyc == e0 + 9) begin
                start   = 1'b1;
                indexes = rand50();
            end else begin
                start = 1'b0;
            end
        end
        chk("busy_after_frame", busy, 0);
        chk("done_pending", q_done.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [49:0] idx;
        int          e0;
        total   = 0;
        bad     = 0;
        cyc     = 0;
        rst     = 1'b0;
        start   = 1'b0;
        indexes = '0;
        cb_data = '0;
        for (int k = 0; k < 256; k++) rom[k] = $urandom;

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // All-zero indexes, entry 0 = 225 Hz
        rom[0] = 32'h00E1_0000;
        chk("ref_225hz", ref_rad(rom[0]), 32'h0000_2CD3);
        run_frame('0, 1'b0);

        // Out-of-range fields wrap
        idx = rand50();
        idx[49:45] = 5'd31;
        idx[39:35] = 5'd13;
        run_frame(idx, 1'b0);

        // Ramp ROM: entry k = (k+1) Hz
        for (int k = 0; k < 256; k++) rom[k] = (k + 1) << 16;
        run_frame(rand50(), 1'b0);

        // Random ROM contents (including negative words) and random indexes
        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 256; k++) rom[k] = $urandom;
            run_frame(rand50(), 1'b0);
        end

        // start while busy is ignored
        run_frame(rand50(), 1'b1);

        // Reset mid-frame aborts the frame
        idx     = rand50();
        indexes = idx;
        start   = 1'b1;
        e0      = cyc + 1;
        push_frame(idx, e0);
        @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + 15) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_zero_outputs("abort");
        q_lsp.delete();
        q_addr.delete();
        q_done.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_frame(rand50(), 1'b0);

        // Idle with no start: monitor flags any strobe
        repeat (20) @(negedge clk);

        // start held high: back-to-back frames, one IDLE cycle between
        idx     = rand50();
        indexes = idx;
        start   = 1'b1;
        e0      = cyc + 1;
        push_frame(idx, e0);
        @(negedge clk);
        idx     = rand50();
        indexes = idx;
        push_frame(idx, e0 + 42);
        while (cyc < e0 + 42) @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + 90) @(negedge clk);
        chk("b2b_busy_end", busy, 0);

        chk("queues_empty", q_lsp.size() + q_addr.size() + q_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
